fft_frame_sequencer: RTL
========================

FFT_FRAME_SEQUENCER -- requirements
Module: fft_frame_sequencer

Interface
REQ-001 Parameter N, default 64, FFT point count; a power of 2, at least 4.
REQ-002 Parameter WIDTH, default 16, sample bit width in two's complement.
REQ-003 Parameter TIMEOUT, default 256, maximum idle cycles allowed in DRAIN between FFT output beats.
REQ-004 Ports (LOG_N = log2(N)):
- clock  in  1  single clock for the block
- reset  in  1  synchronous, active-high reset
- enable  in  1  allows new frames to start
- s_valid  in  1  input sample valid
- s_ready  out  1  input sample accepted when s_valid & s_ready
- s_data  in  WIDTH  real audio sample
- fft_di_en  out  1  FFT input enable
- fft_di_re  out  WIDTH  FFT input, real part
- fft_di_im  out  WIDTH  FFT input, imaginary part
- fft_do_en  in  1  FFT output enable
- fft_do_re  in  WIDTH  FFT output, real part
- fft_do_im  in  WIDTH  FFT output, imaginary part
- m_valid  out  1  spectrum beat valid; no backpressure
- m_index  out  LOG_N  frequency bin number of the beat
- m_re  out  WIDTH  bin value, real part
- m_im  out  WIDTH  bin value, imaginary part
- m_last  out  1  marks the final beat of a frame
- frame_done  out  1  one-cycle pulse when a frame completes
- busy  out  1  high when the state is not IDLE
- err  out  1  sticky error flag
- frame_count  out  16  number of completed frames

Function
REQ-005 The state machine SHALL have four states: IDLE, FILL, STREAM and DRAIN.
REQ-006 IDLE SHALL go to FILL when enable=1. While enable=0 the block SHALL stay in IDLE.
REQ-007 In FILL:
- s_ready=1;
- each accepted sample is written to frame buffer address wr_cnt, and wr_cnt increments;
- acceptance of the N-th sample moves the state to STREAM on the next edge.
REQ-008 s_ready SHALL be 0 in IDLE, STREAM and DRAIN.
REQ-009 The frame buffer SHALL be N x WIDTH with a synchronous read.
- STREAM reads addresses 0..N-1 on consecutive cycles.
- fft_di_en SHALL assert exactly one cycle after STREAM is entered.
- fft_di_en SHALL stay high for exactly N consecutive cycles with no gaps, regardless of s_valid.
REQ-010 During beat k of fft_di_en:
- fft_di_re = buffer[k];
- fft_di_im = 0.
When fft_di_en=0, fft_di_re and fft_di_im SHALL be 0.
REQ-011 After the N-th input beat is issued, the state SHALL move to DRAIN.
REQ-012 Output capture SHALL be active in both STREAM and DRAIN. Each fft_do_en=1 cycle is one beat and increments rd_cnt.
REQ-013 Output beats SHALL be registered with a latency of one cycle:
- m_valid = the registered fft_do_en;
- m_re and m_im = the registered fft_do_re and fft_do_im;
- m_index = bit-reverse of rd_cnt, over LOG_N bits.
REQ-014 m_last=1 on the N-th beat only.
REQ-015 In the cycle after m_last:
- frame_done pulses for one cycle;
- frame_count increments, wrapping from 65535 to 0;
- the state goes to IDLE, or directly to FILL if enable=1.
REQ-016 Once the first output beat has been seen, fft_do_en=0 before N beats have arrived is a gap error. On a gap error:
- err is set;
- the frame is aborted to IDLE;
- frame_done does not pulse;
- frame_count is unchanged.
REQ-017 If DRAIN runs TIMEOUT consecutive cycles without fft_do_en, the block SHALL behave as for a gap error (REQ-016).
REQ-018 fft_do_en=1 in IDLE or FILL SHALL set err. m_valid SHALL stay 0 in that case.
REQ-019 enable dropping mid-frame SHALL NOT abort the frame. The block returns to IDLE after the frame completes.
REQ-020 err SHALL clear only on reset.

Reset
REQ-021 When reset=1 at a clock edge:
- state = IDLE;
- wr_cnt and rd_cnt = 0;
- frame_count = 0;
- all outputs = 0, including s_ready, fft_di_en, m_valid, frame_done, busy and err.
REQ-022 Reset asserted mid-STREAM SHALL drive fft_di_en low at that same edge. Buffer contents are not cleared.

Verification (N=64)
REQ-023 Reset, then 10 idle cycles -> every output is 0 and busy=0.
REQ-024 enable=1 and s_data=k for k=0..63 with s_valid held at 1:
- s_ready drops after the 64th accept;
- fft_di_en is high 64 contiguous cycles;
- fft_di_re runs 0..63 and fft_di_im=0.
REQ-025 s_valid toggling every other cycle during FILL -> the 64-sample FILL takes 128 cycles and fft_di_en is still 64 contiguous cycles.
REQ-026 The model returns 64 fft_do_en beats with re=k:
- m_index runs 0,32,16,48,8,...,63;
- m_last is on the 64th beat;
- frame_done pulses the next cycle;
- frame_count=1.
REQ-027 fft_do_en drops after 10 beats -> err=1, state IDLE, no frame_done, and frame_count unchanged. A separate run with no fft_do_en for 256 DRAIN cycles -> err=1.
REQ-028 reset asserted on STREAM beat 20 -> fft_di_en=0 at that edge. A following full frame then completes normally with frame_count=1.

Source files
------------

// File: rtl/fft_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fft_frame_sequencer
// Brief    : Collects N real samples into a frame buffer, streams them into
//            an FFT core, and forwards the FFT output as an indexed spectrum
//            stream. Gaps or stalls in the FFT output abort the frame.
// Revision : 1.0 - initial release
// ============================================================================
module fft_frame_sequencer #(
    parameter int N       = 64,
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 256
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [WIDTH-1:0]     s_data,
    output logic                 fft_di_en,
    output logic [WIDTH-1:0]     fft_di_re,
    output logic [WIDTH-1:0]     fft_di_im,
    input  logic                 fft_do_en,
    input  logic [WIDTH-1:0]     fft_do_re,
    input  logic [WIDTH-1:0]     fft_do_im,
    output logic                 m_valid,
    output logic [$clog2(N)-1:0] m_index,
    output logic [WIDTH-1:0]     m_re,
    output logic [WIDTH-1:0]     m_im,
    output logic                 m_last,
    output logic                 frame_done,
    output logic                 busy,
    output logic                 err,
    output logic [15:0]          frame_count
);

    localparam int                c_LOG_N     = $clog2(N);
    localparam int                c_TO_W      = $clog2(TIMEOUT + 1);
    localparam logic [c_LOG_N-1:0] c_LAST_ADDR = c_LOG_N'(N - 1);
    localparam logic [c_LOG_N:0]  c_BEATS     = (c_LOG_N + 1)'(N);
    localparam logic [c_LOG_N:0]  c_LAST_BEAT = (c_LOG_N + 1)'(N - 1);
    localparam logic [c_TO_W-1:0] c_TO_LAST   = c_TO_W'(TIMEOUT - 1);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_FILL   = 2'd1;
    localparam logic [1:0] c_STREAM = 2'd2;
    localparam logic [1:0] c_DRAIN  = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [WIDTH-1:0]   r_buf [0:N-1];
    logic [c_LOG_N-1:0] r_wr_cnt;
    logic [c_LOG_N-1:0] r_st_cnt;
    logic [c_LOG_N:0]   r_rd_cnt;
    logic [c_TO_W-1:0]  r_idle_cnt;
    logic               r_di_en;
    logic [WIDTH-1:0]   r_di_re;
    logic               r_m_valid;
    logic               r_m_last;
    logic [c_LOG_N-1:0] r_m_index;
    logic [WIDTH-1:0]   r_m_re;
    logic [WIDTH-1:0]   r_m_im;
    logic               r_frame_done;
    logic               r_err;
    logic [15:0]        r_frame_count;
    logic [c_LOG_N-1:0] w_rev;
    logic               w_accept;
    logic               w_capture;
    logic               w_beat;
    logic               w_complete;
    logic               w_gap;
    logic               w_timeout;
    logic               w_abort;
    logic               w_stray;

    // Output bin index is the bit-reversed beat counter (FFT emits in bit-reversed order)
    for (genvar gi = 0; gi < c_LOG_N; gi++) begin : g_bitrev
        assign w_rev[gi] = r_rd_cnt[c_LOG_N-1-gi];
    end

    // Frame events: accepts, output beats, completion and the two abort causes
    always_comb begin
        w_accept   = (r_state == c_FILL) && s_valid;
        w_capture  = (r_state == c_STREAM) || (r_state == c_DRAIN);
        w_beat     = w_capture && fft_do_en && (r_rd_cnt != c_BEATS);
        w_complete = w_capture && (r_rd_cnt == c_BEATS);
        // A missing beat only counts once the first beat has been seen
        w_gap      = w_capture && !fft_do_en && (r_rd_cnt != '0) && (r_rd_cnt != c_BEATS);
        w_timeout  = (r_state == c_DRAIN) && !fft_do_en && (r_idle_cnt == c_TO_LAST) && !w_complete;
        w_abort    = w_gap || w_timeout;
        w_stray    = ((r_state == c_IDLE) || (r_state == c_FILL)) && fft_do_en;
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (enable) begin
                    w_next_state = c_FILL;
                end
            end
            c_FILL: begin
                if (w_accept && (r_wr_cnt == c_LAST_ADDR)) begin
                    w_next_state = c_STREAM;
                end
            end
            default: begin
                // Completion wins over the STREAM->DRAIN step; abort wins over both
                if (w_abort) begin
                    w_next_state = c_IDLE;
                end else if (w_complete) begin
                    w_next_state = enable ? c_FILL : c_IDLE;
                end else if ((r_state == c_STREAM) && (r_st_cnt == c_LAST_ADDR)) begin
                    w_next_state = c_DRAIN;
                end
            end
        endcase
    end

    // State-decoded outputs
    always_comb begin
        s_ready = (r_state == c_FILL);
        busy    = (r_state != c_IDLE);
    end

    // Frame buffer write port; contents survive reset
    always_ff @(posedge clock) begin
        if (w_accept) begin
            r_buf[r_wr_cnt] <= s_data;
        end
    end

    // Counters, FFT input stream, registered spectrum output and status
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_cnt      <= '0;
            r_st_cnt      <= '0;
            r_rd_cnt      <= '0;
            r_idle_cnt    <= '0;
            r_di_en       <= 1'b0;
            r_di_re       <= '0;
            r_m_valid     <= 1'b0;
            r_m_last      <= 1'b0;
            r_m_index     <= '0;
            r_m_re        <= '0;
            r_m_im        <= '0;
            r_frame_done  <= 1'b0;
            r_err         <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_wr_cnt   <= (r_state == c_FILL) ? (r_wr_cnt + c_LOG_N'(w_accept)) : '0;
            r_st_cnt   <= (r_state == c_STREAM) ? (r_st_cnt + 1'b1) : '0;
            // Synchronous buffer read; the data lands together with fft_di_en
            r_di_en    <= (r_state == c_STREAM);
            r_di_re    <= (r_state == c_STREAM) ? r_buf[r_st_cnt] : '0;
            if (!w_capture) begin
                r_rd_cnt <= '0;
            end else if (w_beat) begin
                r_rd_cnt <= r_rd_cnt + 1'b1;
            end
            r_idle_cnt   <= ((r_state == c_DRAIN) && !fft_do_en) ? (r_idle_cnt + 1'b1) : '0;
            r_m_valid    <= w_beat;
            r_m_last     <= w_beat && (r_rd_cnt == c_LAST_BEAT);
            r_m_index    <= w_beat ? w_rev : '0;
            r_m_re       <= w_beat ? fft_do_re : '0;
            r_m_im       <= w_beat ? fft_do_im : '0;
            r_frame_done <= w_complete;
            if (w_complete) begin
                r_frame_count <= r_frame_count + 16'd1;
            end
            if (w_abort || w_stray) begin
                r_err <= 1'b1;
            end
        end
    end

    assign fft_di_en   = r_di_en;
    assign fft_di_re   = r_di_re;
    assign fft_di_im   = '0;
    assign m_valid     = r_m_valid;
    assign m_index     = r_m_index;
    assign m_re        = r_m_re;
    assign m_im        = r_m_im;
    assign m_last      = r_m_last;
    assign frame_done  = r_frame_done;
    assign err         = r_err;
    assign frame_count = r_frame_count;

endmodule
`default_nettype wire
